cardinal_nic: RTL and testbench

Network interface controller that sits between a processor's NIC port and its ring router, serving as the responder for processor-issued NIC loads and stores. It exposes four memory-mapped registers to the processor: input buffer, input status, output buffer and output status. It moves 64-bit packets to and from the router over a send/ready handshake, one single-entry buffer per direction. Each processor node in the bidirectional ring instantiates one.

---
 rtl/cardinal_nic.sv | 120 ++++++++++++
 tb/tb_cardinal_nic.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// cardinal_nic: responder for processor NIC loads/stores, bridging the
// processor to its ring router with one single-entry buffer per direction.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset, clears all state
//   nicAddr      register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
//   nicDataIn    processor store data
//   nicDataOut   processor load data (registered)
//   nicEn        access strobe
//   nicWrEn      1 = store, 0 = load (qualified by nicEn)
//   netSo        send strobe to router
//   netRo        router ready to accept
//   netDo        packet to router (out buffer, continuously)
//   netSi        router send strobe into the NIC
//   netRi        NIC ready to accept from router
//   netDi        packet from router
//   netPolarity  router's current even/odd phase
//
// Bit numbering is big-endian: bit 0 is the MSB, bit 63 the LSB. Status
// words carry the full flag in bit 63.
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:1]  nicAddr,
  input  logic [0:63] nicDataIn,
  output logic [0:63] nicDataOut,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        netSo,
  input  logic        netRo,
  output logic [0:63] netDo,
  input  logic        netSi,
  output logic        netRi,
  input  logic [0:63] netDi,
  input  logic        netPolarity
);

  logic [0:63] r_in_buf;
  logic        r_in_full;
  logic [0:63] r_out_buf;
  logic        r_out_full;
  logic [0:63] r_data_out;

  logic        w_load;
  logic        w_store_ok;
  logic        w_inject;
  logic        w_eject;
  logic        w_in_clear;
  logic [0:63] w_load_data;

  assign w_load     = nicEn & ~nicWrEn;
  // A store into a full out buffer is dropped even if it drains this cycle.
  assign w_store_ok = nicEn & nicWrEn & (nicAddr == 2'b10) & ~r_out_full;
  // Packets only leave in the ring phase matching their bit 0.
  assign w_inject   = r_out_full & netRo & (r_out_buf[0] == netPolarity);
  // netSi while full is a protocol violation and is ignored.
  assign w_eject    = netSi & ~r_in_full;
  assign w_in_clear = w_load & (nicAddr == 2'b00) & r_in_full;

  assign netSo      = w_inject;
  assign netDo      = r_out_buf;
  assign netRi      = ~r_in_full;
  assign nicDataOut = r_data_out;

  // Load data mux; status words place the full flag in bit 63.
  always_comb begin
    w_load_data = 64'd0;
    case (nicAddr)
      2'b00:   w_load_data = r_in_buf;
      2'b01:   w_load_data = {63'd0, r_in_full};
      2'b10:   w_load_data = r_out_buf;
      2'b11:   w_load_data = {63'd0, r_out_full};
      default: w_load_data = 64'd0;
    endcase
  end

  // Processor load data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= 64'd0;
    end else if (w_load) begin
      r_data_out <= w_load_data;
    end else begin
      r_data_out <= r_data_out;
    end
  end

  // Output (inject) buffer; a store only lands when empty, a drain only
  // happens when full, so the two never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_buf  <= 64'd0;
      r_out_full <= 1'b0;
    end else if (w_store_ok) begin
      r_out_buf  <= nicDataIn;
      r_out_full <= 1'b1;
    end else if (w_inject) begin
      r_out_full <= 1'b0;
    end else begin
      r_out_full <= r_out_full;
    end
  end

  // Input (eject) buffer; arrival needs empty, read-clear needs full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_buf  <= 64'd0;
      r_in_full <= 1'b0;
    end else if (w_eject) begin
      r_in_buf  <= netDi;
      r_in_full <= 1'b1;
    end else if (w_in_clear) begin
      r_in_full <= 1'b0;
    end else begin
      r_in_full <= r_in_full;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios followed by
// randomized traffic, all compared against a register-level reference model.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [0:1]  nicAddr;
  logic [0:63] nicDataIn;
  logic [0:63] nicDataOut;
  logic        nicEn;
  logic        nicWrEn;
  logic        netSo;
  logic        netRo;
  logic [0:63] netDo;
  logic        netSi;
  logic        netRi;
  logic [0:63] netDi;
  logic        netPolarity;

  int n_checks;
  int n_errors;

  // Reference model state, in the programmer's view of the NIC.
  logic [0:63] m_in_buf;
  logic        m_in_full;
  logic [0:63] m_out_buf;
  logic        m_out_full;
  logic [0:63] m_dout;

  cardinal_nic dut (
    .clk(clk), .reset(reset), .nicAddr(nicAddr), .nicDataIn(nicDataIn),
    .nicDataOut(nicDataOut), .nicEn(nicEn), .nicWrEn(nicWrEn), .netSo(netSo),
    .netRo(netRo), .netDo(netDo), .netSi(netSi), .netRi(netRi), .netDi(netDi),
    .netPolarity(netPolarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_buf   = 64'd0;
    m_in_full  = 1'b0;
    m_out_buf  = 64'd0;
    m_out_full = 1'b0;
    m_dout     = 64'd0;
  endfunction

  function automatic logic model_so();
    return m_out_full && netRo && (m_out_buf[0] == netPolarity);
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  function automatic void model_edge();
    logic ld, sent, clr, arrive, stored;
    ld     = nicEn && !nicWrEn;
    sent   = model_so();
    stored = nicEn && nicWrEn && (nicAddr == 2'd2) && !m_out_full;
    arrive = netSi && !m_in_full;
    clr    = ld && (nicAddr == 2'd0) && m_in_full;
    if (ld) begin
      if (nicAddr == 2'd0)      m_dout = m_in_buf;
      else if (nicAddr == 2'd1) m_dout = m_in_full ? 64'd1 : 64'd0;
      else if (nicAddr == 2'd2) m_dout = m_out_buf;
      else                      m_dout = m_out_full ? 64'd1 : 64'd0;
    end
    if (stored) begin
      m_out_buf  = nicDataIn;
      m_out_full = 1'b1;
    end else if (sent) begin
      m_out_full = 1'b0;
    end
    if (arrive) begin
      m_in_buf  = netDi;
      m_in_full = 1'b1;
    end else if (clr) begin
      m_in_full = 1'b0;
    end
  endfunction

  // Check all outputs mid-cycle, then advance one edge (DUT and model).
  task automatic step();
    @(negedge clk);
    check_eq("netSo", {63'd0, netSo}, {63'd0, model_so()});
    check_eq("netRi", {63'd0, netRi}, {63'd0, !m_in_full});
    check_eq("netDo", netDo, m_out_buf);
    check_eq("nicDataOut", nicDataOut, m_dout);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cpu_load(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; nicAddr = a;
    step();
    nicEn = 1'b0;
  endtask

  task automatic cpu_store(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; nicAddr = a; nicDataIn = d;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  initial begin
    logic [0:63] pkt_a;
    logic [0:63] pkt_b;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    nicAddr = 2'd0; nicDataIn = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
    netRo = 1'b0; netSi = 1'b0; netDi = 64'd0; netPolarity = 1'b0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", nicDataOut, 64'd0);
    check_eq("rst_so", {63'd0, netSo}, 64'd0);
    check_eq("rst_ri", {63'd0, netRi}, 64'd1);
    check_eq("rst_do", netDo, 64'd0);
    reset = 1'b1;
    cpu_load(2'd1);
    check_eq("rst_instat", nicDataOut, 64'd0);
    cpu_load(2'd3);
    check_eq("rst_outstat", nicDataOut, 64'd0);

    // Store then inject in the next cycle.
    netPolarity = 1'b0; netRo = 1'b1;
    cpu_store(2'd2, 64'h0123_4567_89AB_CDEF);
    #2;
    check_eq("inj_so", {63'd0, netSo}, 64'd1);
    check_eq("inj_do", netDo, 64'h0123_4567_89AB_CDEF);
    step();
    cpu_load(2'd3);
    check_eq("inj_outstat", nicDataOut, 64'd0);

    // Polarity stall.
    cpu_store(2'd2, 64'h8000_0000_0000_0001);
    #2;
    check_eq("pol_stall0", {63'd0, netSo}, 64'd0);
    step();
    check_eq("pol_stall1", {63'd0, netSo}, 64'd0);
    netPolarity = 1'b1;
    #2;
    check_eq("pol_go", {63'd0, netSo}, 64'd1);
    step();
    check_eq("pol_done", {63'd0, netSo}, 64'd0);

    // Backpressure stall.
    netRo = 1'b0;
    cpu_store(2'd2, 64'h8000_0000_0000_0001);
    step();
    step();
    check_eq("bp_stall", {63'd0, netSo}, 64'd0);
    netRo = 1'b1;
    #2;
    check_eq("bp_go", {63'd0, netSo}, 64'd1);
    step();
    check_eq("bp_done", {63'd0, netSo}, 64'd0);

    // Store into a full out buffer is dropped.
    netRo = 1'b0;
    pkt_a = 64'h1111_2222_3333_4444;
    pkt_b = 64'h5555_6666_7777_8888;
    cpu_store(2'd2, pkt_a);
    cpu_store(2'd2, pkt_b);
    cpu_load(2'd2);
    check_eq("drop_load", nicDataOut, pkt_a);
    netPolarity = pkt_a[0];
    netRo = 1'b1;
    #2;
    check_eq("drop_so", {63'd0, netSo}, 64'd1);
    check_eq("drop_do", netDo, pkt_a);
    step();

    // Eject and read back.
    netSi = 1'b1; netDi = 64'hDEAD_BEEF_0000_0042;
    step();
    netSi = 1'b0;
    #2;
    check_eq("ej_ri0", {63'd0, netRi}, 64'd0);
    cpu_load(2'd1);
    check_eq("ej_instat1", nicDataOut, 64'd1);
    cpu_load(2'd0);
    check_eq("ej_data", nicDataOut, 64'hDEAD_BEEF_0000_0042);
    check_eq("ej_ri1", {63'd0, netRi}, 64'd1);
    cpu_load(2'd1);
    check_eq("ej_instat0", nicDataOut, 64'd0);

    // Asynchronous reset with both buffers full.
    netRo = 1'b0;
    pkt_a = 64'h7654_3210_FEDC_BA98;
    netSi = 1'b1; netDi = 64'hCAFE_F00D_1234_5678;
    cpu_store(2'd2, pkt_a);
    netSi = 1'b0;
    cpu_load(2'd2);
    netPolarity = pkt_a[0];
    netRo = 1'b1;
    #1;
    check_eq("ar_pre_so", {63'd0, netSo}, 64'd1);
    check_eq("ar_pre_ri", {63'd0, netRi}, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("ar_so", {63'd0, netSo}, 64'd0);
    check_eq("ar_ri", {63'd0, netRi}, 64'd1);
    check_eq("ar_dout", nicDataOut, 64'd0);
    check_eq("ar_do", netDo, 64'd0);
    reset = 1'b1;
    model_reset();
    netRo = 1'b0;
    cpu_load(2'd1);
    check_eq("ar_instat", nicDataOut, 64'd0);
    cpu_load(2'd3);
    check_eq("ar_outstat", nicDataOut, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      nicEn       = 1'($urandom_range(0, 1));
      nicWrEn     = 1'($urandom_range(0, 1));
      nicAddr     = 2'($urandom_range(0, 3));
      nicDataIn   = {$urandom, $urandom};
      netRo       = 1'($urandom_range(0, 1));
      netSi       = 1'($urandom_range(0, 1));
      netDi       = {$urandom, $urandom};
      netPolarity = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
